demux1_16_wb: RTL and testbench

DEMUX1_16_WB -- requirements
Module: demux1_16_wb

---
 rtl/demux1_16_wb.sv | 103 ++++++++++
 tb/tb_demux1_16_wb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/demux1_16_wb.sv
// Write-back demultiplexer: routes one producer word into NCH one-entry
// channel buffers (unicast or broadcast) with per-channel consumer acks.

module demux1_16_wb_ch #(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_i,
   input  logic          ack_i,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   output logic          free_o
);

   logic [DW-1:0] data_q;
   logic          vld_q;

   // A write wins over an ack in the same cycle so the channel streams without a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         vld_q  <= 1'b0;
      end else if (wr_i) begin
         data_q <= data_i;
         vld_q  <= 1'b1;
      end else if (ack_i) begin
         vld_q  <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign valid_o = vld_q;
   assign free_o  = ~vld_q | ack_i;

endmodule

module demux1_16_wb #(
   parameter int DW  = 16,
   parameter int NCH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DW-1:0]         in_data,
   input  logic [3:0]            in_sel,
   input  logic                  in_bcast,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NCH*DW-1:0]     out_data,
   output logic [NCH-1:0]        out_valid,
   input  logic [NCH-1:0]        out_ack,
   output logic [7:0]            stall_cnt
);

   logic [NCH-1:0] free;
   logic [NCH-1:0] wr;
   logic           sel_free;
   logic           accept;
   logic           stall;
   logic [7:0]     stall_cnt_q, stall_cnt_d;

   // Out-of-range selects (only possible when NCH < 16) are never ready.
   always_comb begin
      sel_free = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (in_sel == 4'(i)) sel_free = free[i];
   end

   assign in_ready = in_bcast ? &free : sel_free;
   assign accept   = in_valid & in_ready;
   assign stall    = in_valid & ~in_ready;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_ch
         assign wr[g] = accept & (in_bcast | (in_sel == 4'(g)));
         demux1_16_wb_ch #(.DW(DW)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .wr_i    (wr[g]),
            .ack_i   (out_ack[g]),
            .data_i  (in_data),
            .data_o  (out_data[g*DW +: DW]),
            .valid_o (out_valid[g]),
            .free_o  (free[g])
         );
      end
   endgenerate

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_demux1_16_wb.sv
// Bench for demux1_16_wb: vector table plus saturation sequence, expected
// post-edge state queued at drive time and compared one cycle later.

module tb_demux1_16_wb;

   logic         clk;
   logic         rst;
   logic [15:0]  in_data;
   logic [3:0]   in_sel;
   logic         in_bcast;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] out_data;
   logic [15:0]  out_valid;
   logic [15:0]  out_ack;
   logic [7:0]   stall_cnt;

   demux1_16_wb #(.DW(16), .NCH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_bcast  (in_bcast),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [15:0] data;
      logic [3:0]  sel;
      logic        bcast;
      logic        valid;
      logic [15:0] ack;
      logic        rdy;
      logic [15:0] vld;
      logic [7:0]  stl;
   } vec_t;

   typedef struct {
      logic [15:0]  vld;
      logic [7:0]   stl;
      logic [255:0] data;
   } exp_t;

   vec_t        tbl[$];
   exp_t        exp_q[$];
   logic [15:0] mdl [16];
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic vec_t mk(logic r, logic [15:0] d, logic [3:0] s, logic b, logic v,
                               logic [15:0] a, logic rdy, logic [15:0] vld, logic [7:0] stl);
      vec_t t;
      t.rst = r; t.data = d; t.sel = s; t.bcast = b; t.valid = v;
      t.ack = a; t.rdy = rdy; t.vld = vld; t.stl = stl;
      return t;
   endfunction

   function automatic logic [255:0] pack_mdl();
      logic [255:0] p;
      for (int i = 0; i < 16; i++) p[i*16 +: 16] = mdl[i];
      return p;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      exp_t e;
      rst = v.rst; in_data = v.data; in_sel = v.sel; in_bcast = v.bcast;
      in_valid = v.valid; out_ack = v.ack;
      #2;
      chk($sformatf("in_ready[%0d]", idx), {255'd0, in_ready}, {255'd0, v.rdy});
      if (v.rst) begin
         for (int i = 0; i < 16; i++) mdl[i] = '0;
      end else if (v.valid && v.rdy) begin
         for (int i = 0; i < 16; i++)
            if (v.bcast || v.sel == 4'(i)) mdl[i] = v.data;
      end
      e.vld = v.vld; e.stl = v.stl; e.data = pack_mdl();
      exp_q.push_back(e);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard[%0d]: got empty queue expected entry", idx);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("out_valid[%0d]", idx), {240'd0, out_valid}, {240'd0, e.vld});
         chk($sformatf("stall_cnt[%0d]", idx), {248'd0, stall_cnt}, {248'd0, e.stl});
         chk($sformatf("out_data[%0d]", idx), out_data, e.data);
      end
   endtask

   initial begin
      rst = 1'b1; in_data = '0; in_sel = '0; in_bcast = 1'b0; in_valid = 1'b0; out_ack = '0;
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #2;
      chk("reset in_ready", {255'd0, in_ready}, 256'd1);
      chk("reset out_valid", {240'd0, out_valid}, 256'd0);
      chk("reset out_data", out_data, 256'd0);
      chk("reset stall_cnt", {248'd0, stall_cnt}, 256'd0);
      @(posedge clk); #1;

      //          rst  data     sel  bc  v   ack       rdy  vld       stl
      tbl.push_back(mk(0, 16'hBEEF, 5,  0, 1, 16'h0000, 1, 16'h0020, 0));
      tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 16'hFFDF, 1, 16'h0020, 0));
      tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 16'h0020, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h0000, 7,  0, 0, 16'hFFFF, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h1111, 3,  0, 1, 16'h0000, 1, 16'h0008, 0));
      tbl.push_back(mk(0, 16'h2222, 3,  0, 1, 16'h0000, 0, 16'h0008, 1));
      tbl.push_back(mk(0, 16'h2222, 3,  0, 1, 16'h0000, 0, 16'h0008, 2));
      tbl.push_back(mk(0, 16'h2222, 3,  0, 1, 16'h0000, 0, 16'h0008, 3));
      tbl.push_back(mk(0, 16'h2222, 3,  0, 1, 16'h0000, 0, 16'h0008, 4));
      tbl.push_back(mk(0, 16'h2222, 3,  0, 1, 16'h0008, 1, 16'h0008, 4));
      tbl.push_back(mk(0, 16'hAAAA, 10, 0, 1, 16'h0000, 1, 16'h0408, 4));
      tbl.push_back(mk(0, 16'h1234, 0,  1, 1, 16'h0000, 0, 16'h0408, 5));
      tbl.push_back(mk(0, 16'h1234, 0,  1, 1, 16'h0408, 1, 16'hFFFF, 5));
      tbl.push_back(mk(0, 16'h5678, 0,  1, 1, 16'h7FFF, 0, 16'h8000, 6));
      tbl.push_back(mk(0, 16'h5678, 0,  1, 1, 16'h0000, 0, 16'h8000, 7));
      tbl.push_back(mk(0, 16'h5678, 0,  1, 1, 16'h8000, 1, 16'hFFFF, 7));
      tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 16'hFFFF, 1, 16'h0000, 7));
      tbl.push_back(mk(0, 16'h1234, 3,  1, 1, 16'h0000, 1, 16'hFFFF, 7));
      tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 16'hFF0F, 1, 16'h00F0, 7));
      tbl.push_back(mk(1, 16'h9999, 0,  0, 1, 16'h0000, 1, 16'h0000, 0));
      tbl.push_back(mk(0, 16'h0000, 0,  0, 0, 16'h0000, 1, 16'h0000, 0));

      foreach (tbl[i]) step(tbl[i], i);

      // Saturation: hold a blocked write to channel 0 for 300 cycles.
      step(mk(0, 16'hC0DE, 0, 0, 1, 16'h0000, 1, 16'h0001, 0), 100);
      for (int i = 0; i < 300; i++)
         step(mk(0, 16'hD00D, 0, 0, 1, 16'h0000, 0, 16'h0001,
                 (i + 1 > 255) ? 8'd255 : 8'(i + 1)), 200 + i);

      in_valid = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
